button_conditioner: RTL

Front-end input stage of the clock project. It turns the raw, bouncing, asynchronous push-button signals into clean, clock-aligned signals:
- debounced levels;
- one-cycle rising-edge pulses, which are the `btn_pedge[3:0]` bus consumed by the timer and other mode blocks;
- falling-edge pulses;
- optional hold-to-repeat pulses on selected buttons, for fast minute/second setting.

---
 rtl/btn_pkg.sv | 22 ++
 rtl/btn_channel.sv | 134 +++++++++++++
 rtl/button_conditioner.sv | 52 +++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared types and default timing for the push-button front end.
package btn_pkg;

  // Hold-to-repeat sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_t;

  // Default timing at 100 MHz with a 1 ms tick
  localparam int DEF_TICK_CYCLES     = 100_000;
  localparam int DEF_DEBOUNCE_MS     = 10;
  localparam int DEF_REPEAT_DELAY_MS = 500;
  localparam int DEF_REPEAT_RATE_MS  = 100;

  // Width of a counter that must hold values 0..limit
  function automatic int cnt_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-FF synchronizer, tick-based debounce, registered
// edge pulses and (with BTN_AUTOREPEAT_EN defined) a hold-to-repeat FSM.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_MS     = DEF_DEBOUNCE_MS,
  parameter int REPEAT_DELAY_MS = DEF_REPEAT_DELAY_MS,
  parameter int REPEAT_RATE_MS  = DEF_REPEAT_RATE_MS
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic rpt_en,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pedge,
  output logic btn_nedge
);

  localparam int DW = cnt_w(DEBOUNCE_MS);

  logic [1:0]    sync_q;   // sync_q[1] is the clock-aligned input
  logic [DW-1:0] db_cnt;
  logic          level_q;
  logic          level_d;
  logic          rise;
  logic          fall;
  logic          rpt_pulse;

  // Two-flop synchronizer for the asynchronous raw input
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[0], btn_raw};
  end

  // Next debounced level: flips on the tick that completes the persistence window
  always_comb begin
    level_d = level_q;
    if ((sync_q[1] != level_q) && tick && (db_cnt == DW'(DEBOUNCE_MS - 1)))
      level_d = ~level_q;
    rise = level_d & ~level_q;
    fall = ~level_d & level_q;
  end

  // Debounce counter: cleared while input agrees, counts ticks while it differs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_cnt  <= '0;
      level_q <= 1'b0;
    end else begin
      level_q <= level_d;
      if (sync_q[1] == level_q)
        db_cnt <= '0;
      else if (tick)
        db_cnt <= (db_cnt == DW'(DEBOUNCE_MS - 1)) ? '0 : db_cnt + DW'(1);
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
  localparam int RW   = cnt_w(RMAX);

  rpt_state_t    state;
  logic [RW-1:0] rcnt;

  // Repeat pulse on the tick that completes the current interval; a
  // coincident release suppresses it
  always_comb begin
    rpt_pulse = 1'b0;
    if (tick && !fall) begin
      case (state)
        ST_DELAY:  rpt_pulse = (rcnt == RW'(REPEAT_DELAY_MS - 1));
        ST_REPEAT: rpt_pulse = (rcnt == RW'(REPEAT_RATE_MS - 1));
        default:   rpt_pulse = 1'b0;
      endcase
    end
  end

  // Hold-to-repeat sequencer: press arms the delay, then fixed-rate repeats
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      rcnt  <= '0;
    end else if (fall) begin
      state <= ST_IDLE;
      rcnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          rcnt <= '0;
          if (rise && rpt_en) state <= ST_DELAY;
        end
        ST_DELAY: begin
          if (tick) begin
            if (rcnt == RW'(REPEAT_DELAY_MS - 1)) begin
              state <= ST_REPEAT;
              rcnt  <= '0;
            end else begin
              rcnt <= rcnt + RW'(1);
            end
          end
        end
        ST_REPEAT: begin
          if (tick)
            rcnt <= (rcnt == RW'(REPEAT_RATE_MS - 1)) ? '0 : rcnt + RW'(1);
        end
        default: begin
          state <= ST_IDLE;
          rcnt  <= '0;
        end
      endcase
    end
  end
`else
  // No repeat logic: press pulses only; repeat configuration is inert
  logic unused_cfg;
  assign unused_cfg = rpt_en ^ (REPEAT_DELAY_MS != 0) ^ (REPEAT_RATE_MS != 0);
  assign rpt_pulse  = 1'b0;
`endif

  // Registered level and edge pulses, aligned with the level change
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_level <= 1'b0;
      btn_pedge <= 1'b0;
      btn_nedge <= 1'b0;
    end else begin
      btn_level <= level_d;
      btn_pedge <= rise | rpt_pulse;
      btn_nedge <= fall;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end: shared 1 ms prescaler plus N_BTN conditioned
// channels. Define BTN_AUTOREPEAT_EN to build hold-to-repeat on the
// channels selected by REPEAT_MASK.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int               N_BTN           = 4,
  parameter int               TICK_CYCLES     = DEF_TICK_CYCLES,
  parameter int               DEBOUNCE_MS     = DEF_DEBOUNCE_MS,
  parameter int               REPEAT_DELAY_MS = DEF_REPEAT_DELAY_MS,
  parameter int               REPEAT_RATE_MS  = DEF_REPEAT_RATE_MS,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = 4'b0110
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pedge,
  output logic [N_BTN-1:0] btn_nedge
);

  localparam int PW = cnt_w(TICK_CYCLES);

  logic [PW-1:0] pcnt;
  logic          tick;

  assign tick = (pcnt == PW'(TICK_CYCLES - 1));

  // Shared prescaler: one-cycle tick each time it wraps
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pcnt <= '0;
    else          pcnt <= tick ? '0 : pcnt + PW'(1);
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_MS     (DEBOUNCE_MS),
      .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
      .REPEAT_RATE_MS  (REPEAT_RATE_MS)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .tick      (tick),
      .rpt_en    (REPEAT_MASK[i]),
      .btn_raw   (btn_raw[i]),
      .btn_level (btn_level[i]),
      .btn_pedge (btn_pedge[i]),
      .btn_nedge (btn_nedge[i])
    );
  end

endmodule
